// File: rtl/sampletest_msaa.sv
// ---------------------------------------------------------------------------
// sampletest_msaa
//
// Multisample raster coverage tester. One pixel plus one triangle is accepted
// per valid/ready handshake; the block then spends SAMPLES cycles testing one
// jittered sub-pixel location per cycle against the three edge equations.
// A pixel with any covered sample is emitted with its coverage mask and hit
// count. A pixel with no covered sample is dropped silently.
//
// Build option:
//   SAMPLETEST_TWO_SIDED_EN  when defined, back-facing triangles also produce
//                            coverage (sign-mirrored edge test). When not
//                            defined, only front-facing triangles hit.
//
// Ports:
//   clk          clock
//   rst          synchronous active-high reset
//   tri_in       triangle; vertex v axis a at [(v*AXIS+a)*SIGFIG +: SIGFIG],
//                axis 0 = x, 1 = y, 2 = z (signed fixed point)
//   color_in     triangle color, channel c at [c*SIGFIG +: SIGFIG]
//   pixel_in     pixel origin, x at [SIGFIG-1:0], y at [2*SIGFIG-1:SIGFIG]
//   offs_in      jitter offsets, sample i x at [(2i)*SIGFIG +: SIGFIG],
//                y at [(2i+1)*SIGFIG +: SIGFIG]
//   in_valid     input beat valid
//   in_ready     block is idle and can accept a beat
//   hit_out      {pixel x, pixel y, z of vertex 0} (x in the top slice)
//   color_out    color latched with the pixel
//   cov_mask_out bit i set when sample i is inside the triangle
//   cov_cnt_out  number of set bits in cov_mask_out
//   out_valid    output beat valid
//   out_ready    downstream accepts the output beat
// ---------------------------------------------------------------------------
module sampletest_msaa #(
    parameter int SIGFIG  = 24,
    parameter int RADIX   = 10,
    parameter int VERTS   = 3,
    parameter int AXIS    = 3,
    parameter int COLORS  = 3,
    parameter int SAMPLES = 4,
    parameter int SUBSF   = 17,
    parameter int MULSF   = 32,
    localparam int CNTW   = $clog2(SAMPLES + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [SIGFIG*VERTS*AXIS-1:0]     tri_in,
    input  logic [SIGFIG*COLORS-1:0]         color_in,
    input  logic [SIGFIG*2-1:0]              pixel_in,
    input  logic [SIGFIG*SAMPLES*2-1:0]      offs_in,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [SIGFIG*AXIS-1:0]           hit_out,
    output logic [SIGFIG*COLORS-1:0]         color_out,
    output logic [SAMPLES-1:0]               cov_mask_out,
    output logic [CNTW-1:0]                  cov_cnt_out,
    output logic                             out_valid,
    input  logic                             out_ready
);

    // Sample index needs at least one bit even for the single-sample build.
    localparam int IDXW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;
    // The fraction width does not change the integer edge arithmetic.
    localparam int unused_radix = RADIX;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TEST = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t                      state_q;
    logic [IDXW-1:0]             idx_q;
    logic [SAMPLES-1:0]          mask_q;
    logic [CNTW-1:0]             cnt_q;
    logic                        out_valid_q;
    logic [SIGFIG-1:0]           vx_q [VERTS];
    logic [SIGFIG-1:0]           vy_q [VERTS];
    logic [SIGFIG-1:0]           z0_q;
    logic [SIGFIG-1:0]           px_q;
    logic [SIGFIG-1:0]           py_q;
    logic [SIGFIG*COLORS-1:0]    color_q;
    logic [SIGFIG*SAMPLES*2-1:0] offs_q;

    logic [SIGFIG-1:0]           sx_s;
    logic [SIGFIG-1:0]           sy_s;
    logic [SIGFIG-1:0]           dx_s [VERTS];
    logic [SIGFIG-1:0]           dy_s [VERTS];
    logic signed [MULSF-1:0]     ex_s [VERTS];
    logic signed [MULSF-1:0]     ey_s [VERTS];
    logic signed [MULSF-1:0]     d0_s;
    logic signed [MULSF-1:0]     d1_s;
    logic signed [MULSF-1:0]     d2_s;
    logic                        front_s;
    logic                        back_s;
    logic                        hit_s;
    logic [SAMPLES-1:0]          mask_d;
    logic [CNTW-1:0]             cnt_d;
    logic                        unused_bits_s;

    // Number of covered samples in a mask.
    function automatic logic [CNTW-1:0] popcount(input logic [SAMPLES-1:0] m);
        logic [CNTW-1:0] c;
        c = '0;
        for (int i = 0; i < SAMPLES; i++) begin
            c = c + CNTW'(m[i]);
        end
        return c;
    endfunction

    // Ready only while idle; reset forces it low in the same cycle.
    assign in_ready     = (state_q == IDLE) && !rst;
    assign out_valid    = out_valid_q;
    assign hit_out      = {px_q, py_q, z0_q};
    assign color_out    = color_q;
    assign cov_mask_out = mask_q;
    assign cov_cnt_out  = cnt_q;

    // Edge evaluation for the sample selected by idx_q and the next mask.
    always_comb begin
        sx_s          = px_q + offs_q[int'(idx_q)*2*SIGFIG +: SIGFIG];
        sy_s          = py_q + offs_q[(int'(idx_q)*2+1)*SIGFIG +: SIGFIG];
        unused_bits_s = ^{tri_in[(1*AXIS+2)*SIGFIG +: SIGFIG],
                          tri_in[(2*AXIS+2)*SIGFIG +: SIGFIG]};
        for (int v = 0; v < VERTS; v++) begin
            dx_s[v] = vx_q[v] - sx_s;
            dy_s[v] = vy_q[v] - sy_s;
            // Shifted vertex truncated to SUBSF, then sign-extended.
            ex_s[v] = {{(MULSF-SUBSF){dx_s[v][SUBSF-1]}}, dx_s[v][SUBSF-1:0]};
            ey_s[v] = {{(MULSF-SUBSF){dy_s[v][SUBSF-1]}}, dy_s[v][SUBSF-1:0]};
            unused_bits_s = unused_bits_s ^ (^dx_s[v][SIGFIG-1:SUBSF])
                                          ^ (^dy_s[v][SIGFIG-1:SUBSF]);
        end
        d0_s = ex_s[1] * ey_s[0] - ex_s[0] * ey_s[1];
        d1_s = ex_s[1] * ey_s[2] - ex_s[2] * ey_s[1];
        d2_s = ex_s[0] * ey_s[2] - ex_s[2] * ey_s[0];
        // d1 must be strictly negative, so samples exactly on edge 1 miss.
        front_s = !d0_s[MULSF-1] &&  d1_s[MULSF-1] && !d2_s[MULSF-1];
        back_s  =  d0_s[MULSF-1] && !d1_s[MULSF-1] &&  d2_s[MULSF-1];
`ifdef SAMPLETEST_TWO_SIDED_EN
        hit_s = front_s || back_s;
`else
        hit_s = front_s;
`endif
        mask_d         = mask_q;
        mask_d[idx_q]  = hit_s;
        cnt_d          = popcount(mask_d);
    end

    // Control FSM plus latched pixel data and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            z0_q        <= '0;
            px_q        <= '0;
            py_q        <= '0;
            color_q     <= '0;
            offs_q      <= '0;
            for (int v = 0; v < VERTS; v++) begin
                vx_q[v] <= '0;
                vy_q[v] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        for (int v = 0; v < VERTS; v++) begin
                            vx_q[v] <= tri_in[(v*AXIS+0)*SIGFIG +: SIGFIG];
                            vy_q[v] <= tri_in[(v*AXIS+1)*SIGFIG +: SIGFIG];
                        end
                        z0_q    <= tri_in[2*SIGFIG +: SIGFIG];
                        px_q    <= pixel_in[SIGFIG-1:0];
                        py_q    <= pixel_in[2*SIGFIG-1:SIGFIG];
                        color_q <= color_in;
                        offs_q  <= offs_in;
                        mask_q  <= '0;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                        state_q <= TEST;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                TEST: begin
                    mask_q <= mask_d;
                    cnt_q  <= cnt_d;
                    if (idx_q == IDXW'(SAMPLES - 1)) begin
                        idx_q <= '0;
                        // Pixels with no covered sample never reach the output.
                        if (|mask_d) begin
                            state_q     <= EMIT;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q     <= IDLE;
                        end
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        out_valid_q <= 1'b1;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sampletest_msaa.sv
module tb_sampletest_msaa;

    localparam int SIGFIG  = 24;
    localparam int VERTS   = 3;
    localparam int AXIS    = 3;
    localparam int COLORS  = 3;
    localparam int SAMPLES = 4;
    localparam int CNTW    = $clog2(SAMPLES + 1);

    logic                        clk = 1'b0;
    logic                        rst;
    logic [SIGFIG*VERTS*AXIS-1:0] tri_in;
    logic [SIGFIG*COLORS-1:0]    color_in;
    logic [SIGFIG*2-1:0]         pixel_in;
    logic [SIGFIG*SAMPLES*2-1:0] offs_in;
    logic                        in_valid;
    logic                        in_ready;
    logic [SIGFIG*AXIS-1:0]      hit_out;
    logic [SIGFIG*COLORS-1:0]    color_out;
    logic [SAMPLES-1:0]          cov_mask_out;
    logic [CNTW-1:0]             cov_cnt_out;
    logic                        out_valid;
    logic                        out_ready;

    int n_cmp = 0;
    int n_err = 0;

    // scenario data, plain integers
    int tvx [VERTS];
    int tvy [VERTS];
    int tvz [VERTS];
    int pxi;
    int pyi;
    int ox  [SAMPLES];
    int oy  [SAMPLES];
    int col [COLORS];

    always #5 clk = ~clk;

    sampletest_msaa #(.SAMPLES(SAMPLES)) dut (
        .clk          (clk),
        .rst          (rst),
        .tri_in       (tri_in),
        .color_in     (color_in),
        .pixel_in     (pixel_in),
        .offs_in      (offs_in),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .hit_out      (hit_out),
        .color_out    (color_out),
        .cov_mask_out (cov_mask_out),
        .cov_cnt_out  (cov_cnt_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready)
    );

    // Reference: full-precision edge functions evaluated per sample.
    function automatic logic [SAMPLES-1:0] ref_mask();
        logic [SAMPLES-1:0] m;
        longint sx, sy, x0, y0, x1, y1, x2, y2, d0, d1, d2;
        bit front, back;
        m = '0;
        for (int s = 0; s < SAMPLES; s++) begin
            sx = longint'(pxi) + longint'(ox[s]);
            sy = longint'(pyi) + longint'(oy[s]);
            x0 = tvx[0] - sx; y0 = tvy[0] - sy;
            x1 = tvx[1] - sx; y1 = tvy[1] - sy;
            x2 = tvx[2] - sx; y2 = tvy[2] - sy;
            d0 = x1 * y0 - x0 * y1;
            d1 = x1 * y2 - x2 * y1;
            d2 = x0 * y2 - x2 * y0;
            front = (d0 >= 0) && (d1 < 0) && (d2 >= 0);
            back  = (d0 < 0) && (d1 >= 0) && (d2 < 0);
`ifdef SAMPLETEST_TWO_SIDED_EN
            m[s] = front || back;
`else
            m[s] = front;
`endif
        end
        return m;
    endfunction

    function automatic logic [SIGFIG*AXIS-1:0] exp_hit();
        return {pxi[SIGFIG-1:0], pyi[SIGFIG-1:0], tvz[0][SIGFIG-1:0]};
    endfunction

    function automatic logic [SIGFIG*COLORS-1:0] exp_color();
        logic [SIGFIG*COLORS-1:0] c;
        for (int i = 0; i < COLORS; i++) c[i*SIGFIG +: SIGFIG] = col[i][SIGFIG-1:0];
        return c;
    endfunction

    // Pack scenario data onto the input ports and raise in_valid.
    task automatic apply_beat();
        for (int v = 0; v < VERTS; v++) begin
            tri_in[(v*AXIS+0)*SIGFIG +: SIGFIG] = tvx[v][SIGFIG-1:0];
            tri_in[(v*AXIS+1)*SIGFIG +: SIGFIG] = tvy[v][SIGFIG-1:0];
            tri_in[(v*AXIS+2)*SIGFIG +: SIGFIG] = tvz[v][SIGFIG-1:0];
        end
        color_in = exp_color();
        pixel_in = {pyi[SIGFIG-1:0], pxi[SIGFIG-1:0]};
        for (int s = 0; s < SAMPLES; s++) begin
            offs_in[(2*s)*SIGFIG +: SIGFIG]   = ox[s][SIGFIG-1:0];
            offs_in[(2*s+1)*SIGFIG +: SIGFIG] = oy[s][SIGFIG-1:0];
        end
        in_valid = 1'b1;
    endtask

    // Called at the negedge of cycle t+1; returns the cycle offset at which
    // out_valid was seen, or the budget if it never came.
    task automatic wait_valid(input int budget, output int cyc);
        cyc = 1;
        while (out_valid !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic set_tri_front();
        tvx[0] = 0;    tvy[0] = 0;
        tvx[1] = 0;    tvy[1] = 2048;
        tvx[2] = 2048; tvy[2] = 0;
        tvz[0] = 12345; tvz[1] = 222; tvz[2] = 333;
        col[0] = 24'h112233; col[1] = 24'h445566; col[2] = 24'hABCDEF;
    endtask

    task automatic set_offs_zero();
        for (int s = 0; s < SAMPLES; s++) begin ox[s] = 0; oy[s] = 0; end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        tri_in = '0; color_in = '0; pixel_in = '0; offs_in = '0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
        end
        n_cmp++;
        if (hit_out !== '0 || color_out !== '0 || cov_mask_out !== '0 || cov_cnt_out !== '0) begin
            n_err++; $display("FAIL reset_data: hit=%h color=%h mask=%b cnt=%0d want all 0",
                              hit_out, color_out, cov_mask_out, cov_cnt_out);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release: in_ready=%b want 1", in_ready);
        end
    endtask

    // Cases 1 and 2: full coverage and hypotenuse samples.
    task automatic test_coverage();
        int cyc;
        logic [SAMPLES-1:0] want_m [2];
        logic [CNTW-1:0]    want_c [2];
        want_m[0] = 4'b1111; want_c[0] = 3'd4;
        want_m[1] = 4'b0001; want_c[1] = 3'd1;
        for (int k = 0; k < 2; k++) begin
            set_tri_front();
            if (k == 0) begin
                pxi = 256; pyi = 256; set_offs_zero();
            end else begin
                pxi = 1024; pyi = 1024;
                ox[0] = -256; oy[0] = -256; ox[1] = 256; oy[1] = -256;
                ox[2] = -256; oy[2] = 256;  ox[3] = 256; oy[3] = 256;
            end
            @(negedge clk);
            apply_beat();
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL cov%0d_accept: in_ready=%b want 1", k, in_ready);
            end
            @(negedge clk);
            in_valid = 1'b0;
            wait_valid(5, cyc);
            n_cmp++;
            if (cyc != 5 || out_valid !== 1'b1) begin
                n_err++; $display("FAIL cov%0d_latency: cycle=%0d out_valid=%b want 5 1", k, cyc, out_valid);
            end
            n_cmp++;
            if (cov_mask_out !== want_m[k] || cov_cnt_out !== want_c[k]) begin
                n_err++; $display("FAIL cov%0d_mask: mask=%b cnt=%0d want %b %0d",
                                  k, cov_mask_out, cov_cnt_out, want_m[k], want_c[k]);
            end
            n_cmp++;
            if (hit_out !== exp_hit() || color_out !== exp_color()) begin
                n_err++; $display("FAIL cov%0d_data: hit=%h color=%h want %h %h",
                                  k, hit_out, color_out, exp_hit(), exp_color());
            end
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_err++; $display("FAIL cov%0d_release: out_valid=%b in_ready=%b want 0 1", k, out_valid, in_ready);
            end
        end
    endtask

    // Cases 3 and 4: outside pixel, and the reverse-wound triangle.
    task automatic test_drop();
        int cyc;
        logic want_emit;
        for (int k = 0; k < 2; k++) begin
            set_tri_front(); set_offs_zero();
            if (k == 0) begin
                pxi = 3072; pyi = 3072; want_emit = 1'b0;
            end else begin
                tvx[1] = 2048; tvy[1] = 0; tvx[2] = 0; tvy[2] = 2048;
                pxi = 256; pyi = 256;
`ifdef SAMPLETEST_TWO_SIDED_EN
                want_emit = 1'b1;
`else
                want_emit = 1'b0;
`endif
            end
            @(negedge clk);
            apply_beat();
            @(negedge clk);
            in_valid = 1'b0;
            wait_valid(5, cyc);
            n_cmp++;
            if (cyc != 5 || out_valid !== want_emit) begin
                n_err++; $display("FAIL drop%0d_valid: cycle=%0d out_valid=%b want 5 %b", k, cyc, out_valid, want_emit);
            end
            if (want_emit) begin
                n_cmp++;
                if (cov_mask_out !== 4'b1111 || cov_cnt_out !== 3'd4) begin
                    n_err++; $display("FAIL drop%0d_mask: mask=%b cnt=%0d want 1111 4", k, cov_mask_out, cov_cnt_out);
                end
                @(negedge clk);
            end else begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++; $display("FAIL drop%0d_ready: in_ready=%b want 1 at t+5", k, in_ready);
                end
            end
        end
    endtask

    // Case 5: hold under back-pressure, then accept the next beat right after.
    task automatic test_back_to_back();
        int cyc;
        logic [SIGFIG*AXIS-1:0] hold_hit;
        set_tri_front(); set_offs_zero(); pxi = 256; pyi = 256;
        out_ready = 1'b0;
        @(negedge clk);
        apply_beat();
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(5, cyc);
        n_cmp++;
        if (cyc != 5 || out_valid !== 1'b1) begin
            n_err++; $display("FAIL bp_latency: cycle=%0d out_valid=%b want 5 1", cyc, out_valid);
        end
        hold_hit = exp_hit();
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || cov_mask_out !== 4'b1111 ||
                cov_cnt_out !== 3'd4 || hit_out !== hold_hit) begin
                n_err++; $display("FAIL bp_hold%0d: valid=%b ready=%b mask=%b cnt=%0d hit=%h want 1 0 1111 4 %h",
                                  i, out_valid, in_ready, cov_mask_out, cov_cnt_out, hit_out, hold_hit);
            end
            @(negedge clk);
        end
        // release and present the next pixel in the same cycle
        out_ready = 1'b1;
        pxi = 512; pyi = 300;
        apply_beat();
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++; $display("FAIL bp_busy: in_ready=%b want 0 while emitting", in_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++; $display("FAIL bp_next_accept: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(5, cyc);
        n_cmp++;
        if (cyc != 5 || out_valid !== 1'b1 || hit_out !== exp_hit() || cov_mask_out !== ref_mask()) begin
            n_err++; $display("FAIL bp_second: cycle=%0d valid=%b hit=%h mask=%b want 5 1 %h %b",
                              cyc, out_valid, hit_out, cov_mask_out, exp_hit(), ref_mask());
        end
        @(negedge clk);
    endtask

    // Case 6: reset in the middle of TEST discards the pixel.
    task automatic test_reset_mid();
        int seen;
        set_tri_front(); set_offs_zero(); pxi = 256; pyi = 256;
        @(negedge clk);
        apply_beat();
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_idle: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_err++; $display("FAIL rstmid_noemit: out_valid cycles=%0d want 0", seen);
        end
        @(negedge clk);
        apply_beat();
        @(negedge clk);
        in_valid = 1'b0;
        wait_valid(5, seen);
        n_cmp++;
        if (seen != 5 || out_valid !== 1'b1 || cov_mask_out !== 4'b1111 || cov_cnt_out !== 3'd4) begin
            n_err++; $display("FAIL rstmid_fresh: cycle=%0d valid=%b mask=%b cnt=%0d want 5 1 1111 4",
                              seen, out_valid, cov_mask_out, cov_cnt_out);
        end
        @(negedge clk);
    endtask

    // Randomized pixels and triangles with random back-pressure.
    task automatic test_random();
        int cyc, span, stall;
        logic [SAMPLES-1:0] wm;
        for (int n = 0; n < 60; n++) begin
            span = (n % 2 == 0) ? 2000 : 20000;
            pxi = int'($urandom_range(0, 4096)) - 2048;
            pyi = int'($urandom_range(0, 4096)) - 2048;
            for (int v = 0; v < VERTS; v++) begin
                tvx[v] = pxi + int'($urandom_range(0, 2*span)) - span;
                tvy[v] = pyi + int'($urandom_range(0, 2*span)) - span;
                tvz[v] = int'($urandom_range(0, 24'hFFFFFF));
            end
            for (int s = 0; s < SAMPLES; s++) begin
                ox[s] = int'($urandom_range(0, 2048)) - 1024;
                oy[s] = int'($urandom_range(0, 2048)) - 1024;
            end
            for (int c = 0; c < COLORS; c++) col[c] = int'($urandom_range(0, 24'hFFFFFF));
            wm = ref_mask();
            stall = int'($urandom_range(0, 3));
            out_ready = (stall == 0);
            @(negedge clk);
            apply_beat();
            @(negedge clk);
            in_valid = 1'b0;
            wait_valid(5, cyc);
            n_cmp++;
            if (cyc != 5 || out_valid !== (wm != '0)) begin
                n_err++; $display("FAIL rnd%0d_valid: cycle=%0d out_valid=%b want 5 %b", n, cyc, out_valid, (wm != '0));
            end
            if (wm != '0) begin
                n_cmp++;
                if (cov_mask_out !== wm || cov_cnt_out !== CNTW'($countones(wm)) ||
                    hit_out !== exp_hit() || color_out !== exp_color()) begin
                    n_err++; $display("FAIL rnd%0d_data: mask=%b cnt=%0d hit=%h color=%h want %b %0d %h %h",
                                      n, cov_mask_out, cov_cnt_out, hit_out, color_out,
                                      wm, $countones(wm), exp_hit(), exp_color());
                end
                for (int i = 0; i < stall; i++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (out_valid !== 1'b1 || cov_mask_out !== wm) begin
                        n_err++; $display("FAIL rnd%0d_hold: valid=%b mask=%b want 1 %b", n, out_valid, cov_mask_out, wm);
                    end
                end
                out_ready = 1'b1;
                @(negedge clk);
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_err++; $display("FAIL rnd%0d_done: out_valid=%b want 0", n, out_valid);
                end
            end else begin
                out_ready = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_coverage();
        test_drop();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
